// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler.
package disp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StShow,
        StExc
    } state_e;

    localparam logic [7:0]  EXC_PREFIX = 8'hEE;
    localparam int unsigned SHOW_W     = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after rr_ptr_i, wrapping modulo NUM_SRC.
module rr_arbiter #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [2:0]         rr_ptr_i,
    output logic [NUM_SRC-1:0] win_o,
    output logic               found_o
);

    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        // Two passes: sources above the pointer first, then wrap to the ones at or below it.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found_o && req_i[i] && (i > int'(rr_ptr_i))) begin
                win_o[i] = 1'b1;
                found_o  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found_o && req_i[i] && (i <= int'(rr_ptr_i))) begin
                win_o[i] = 1'b1;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_sched.sv
// Round-robin time-multiplexer for the 4-digit hex display, with exception preemption.
// Optional DISP_SCHED_LIVE_EN: show tracks the granted source every cycle instead of a snapshot.
module disp_sched
    import disp_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [SHOW_W*NUM_SRC-1:0] src_data,
    input  logic                      exc_req,
    input  logic [7:0]                exc_code,
    output logic [SHOW_W-1:0]         show,
    output logic                      valid,
    output logic [NUM_SRC-1:0]        grant,
    output logic [2:0]                src_id,
    output logic                      done
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntPen  = CNT_W'(DWELL_CYCLES - 2);
    localparam logic [2:0]       PtrInit = 3'(NUM_SRC - 1);

    state_e              state_q, state_d;
    logic [SHOW_W-1:0]   show_q, show_d;
    logic                valid_q, valid_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [2:0]          src_id_q, src_id_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;

    logic [NUM_SRC-1:0]  win;
    logic                found;
    logic [2:0]          win_id;
    logic [SHOW_W-1:0]   win_data;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_arbiter (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .win_o    (win),
        .found_o  (found)
    );

    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win[i]) begin
                win_id   = 3'(i);
                win_data = src_data[SHOW_W*i +: SHOW_W];
            end
        end
    end

`ifdef DISP_SCHED_LIVE_EN
    logic [SHOW_W-1:0] cur_data;

    always_comb begin
        cur_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_id_q == 3'(i)) begin
                cur_data = src_data[SHOW_W*i +: SHOW_W];
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        show_d   = show_q;
        valid_d  = valid_q;
        grant_d  = grant_q;
        src_id_d = src_id_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;

        // Exception wins from every state; an interrupted dwell is dropped without done.
        if (exc_req) begin
            state_d  = StExc;
            show_d   = {EXC_PREFIX, exc_code};
            valid_d  = 1'b1;
            grant_d  = '0;
            src_id_d = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_d = 1'b0;
                    if (|req) state_d = StArb;
                end
                StArb: begin
                    if (found) begin
                        state_d  = StShow;
                        show_d   = win_data;
                        valid_d  = 1'b1;
                        grant_d  = win;
                        src_id_d = win_id;
                        rr_ptr_d = win_id;
                        cnt_d    = '0;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end
                end
                StShow: begin
`ifdef DISP_SCHED_LIVE_EN
                    show_d = cur_data;
`endif
                    if (cnt_q == CntLast) begin
                        grant_d  = '0;
                        src_id_d = '0;
                        cnt_d    = '0;
                        state_d  = (|req) ? StArb : StIdle;
                        valid_d  = |req;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        // Registered pulse lands on the final granted cycle.
                        done_d = (cnt_q == CntPen);
                    end
                end
                StExc: begin
                    state_d = (|req) ? StArb : StIdle;
                    valid_d = |req;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= StIdle;
            show_q   <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
            src_id_q <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= PtrInit;
        end else begin
            state_q  <= state_d;
            show_q   <= show_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            src_id_q <= src_id_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign show   = show_q;
    assign valid  = valid_q;
    assign grant  = grant_q;
    assign src_id = src_id_q;
    assign done   = done_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with NUM_SRC=4, DWELL_CYCLES=4; honours DISP_SCHED_LIVE_EN.
module tb_disp_sched;

    logic        sysclk;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] src_data;
    logic        exc_req;
    logic [7:0]  exc_code;
    logic [15:0] show;
    logic        valid;
    logic [3:0]  grant;
    logic [2:0]  src_id;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic        exc;
        logic [7:0]  code;
        logic [15:0] show;
        logic        valid;
        logic [3:0]  grant;
        logic [2:0]  id;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    disp_sched #(
        .NUM_SRC      (4),
        .DWELL_CYCLES (4),
        .CNT_W        (3)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .req      (req),
        .src_data (src_data),
        .exc_req  (exc_req),
        .exc_code (exc_code),
        .show     (show),
        .valid    (valid),
        .grant    (grant),
        .src_id   (src_id),
        .done     (done)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_show, input logic e_valid,
                             input logic [3:0] e_grant, input logic [2:0] e_id,
                             input logic e_done);
        check({tag, " show"}, show, e_show);
        check({tag, " valid"}, 16'(valid), 16'(e_valid));
        check({tag, " grant"}, 16'(grant), 16'(e_grant));
        check({tag, " src_id"}, 16'(src_id), 16'(e_id));
        check({tag, " done"}, 16'(done), 16'(e_done));
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic e, input logic [7:0] c,
                       input logic [15:0] s, input logic v, input logic [3:0] g,
                       input logic [2:0] id, input logic d);
        vec_t x;
        x.rst = r; x.req = rq; x.exc = e; x.code = c;
        x.show = s; x.valid = v; x.grant = g; x.id = id; x.done = d;
        vecs.push_back(x);
    endtask

    logic [15:0] live_exp;

    initial begin
        reset    = 1'b1;
        req      = 4'b1111;
        exc_req  = 1'b0;
        exc_code = 8'h00;
        src_data = {16'hBEEF, 16'h2222, 16'h1234, 16'hA000};

        // rst req exc code | show valid grant id done
        for (int i = 0; i < 3; i++) add(1, 4'hF, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 0);
        add(0, 4'hF, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 0);
        add(0, 4'hF, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 0);
        add(0, 4'hF, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 0);
        add(0, 4'hF, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 0);
        add(0, 4'hF, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 1);
        add(0, 4'hF, 0, 8'h00, 16'hA000, 1, 4'h0, 0, 0);
        // round robin over sources 1 and 3
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 1);
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h0, 0, 0);
        add(0, 4'hA, 0, 8'h00, 16'hBEEF, 1, 4'h8, 3, 0);
        add(0, 4'hA, 0, 8'h00, 16'hBEEF, 1, 4'h8, 3, 0);
        add(0, 4'hA, 0, 8'h00, 16'hBEEF, 1, 4'h8, 3, 0);
        add(0, 4'hA, 0, 8'h00, 16'hBEEF, 1, 4'h8, 3, 1);
        add(0, 4'hA, 0, 8'h00, 16'hBEEF, 1, 4'h0, 0, 0);
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'hA, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 1);
        // source 2 wins, then drops req mid-dwell
        add(0, 4'h4, 0, 8'h00, 16'h1234, 1, 4'h0, 0, 0);
        add(0, 4'h4, 0, 8'h00, 16'h2222, 1, 4'h4, 2, 0);
        add(0, 4'h0, 0, 8'h00, 16'h2222, 1, 4'h4, 2, 0);
        add(0, 4'h0, 0, 8'h00, 16'h2222, 1, 4'h4, 2, 0);
        add(0, 4'h0, 0, 8'h00, 16'h2222, 1, 4'h4, 2, 1);
        add(0, 4'h0, 0, 8'h00, 16'h2222, 0, 4'h0, 0, 0);
        add(0, 4'h0, 0, 8'h00, 16'h2222, 0, 4'h0, 0, 0);
        // exception in the 2nd cycle of source 0's dwell
        add(0, 4'h3, 0, 8'h00, 16'h2222, 0, 4'h0, 0, 0);
        add(0, 4'h3, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 0);
        add(0, 4'h3, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 0);
        add(0, 4'h3, 1, 8'h0C, 16'hEE0C, 1, 4'h0, 0, 0);
        add(0, 4'h3, 1, 8'h5A, 16'hEE5A, 1, 4'h0, 0, 0);
        add(0, 4'h3, 0, 8'h5A, 16'hEE5A, 1, 4'h0, 0, 0);
        add(0, 4'h3, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'h3, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'h3, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 0);
        add(0, 4'h3, 0, 8'h00, 16'h1234, 1, 4'h2, 1, 1);
        // exception raised in the done cycle
        add(0, 4'h3, 1, 8'h33, 16'hEE33, 1, 4'h0, 0, 0);
        add(0, 4'h0, 0, 8'h00, 16'hEE33, 0, 4'h0, 0, 0);
        // reset mid-dwell restores rr_ptr so source 0 wins again
        add(0, 4'h1, 0, 8'h00, 16'hEE33, 0, 4'h0, 0, 0);
        add(0, 4'h1, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 0);
        add(0, 4'h1, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 0);
        add(1, 4'h1, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 0);
        add(0, 4'h3, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 0);
        add(0, 4'h3, 0, 8'h00, 16'hA000, 1, 4'h1, 0, 0);
        // reset mid-exception
        add(0, 4'h3, 1, 8'h77, 16'hEE77, 1, 4'h0, 0, 0);
        add(1, 4'h0, 1, 8'h77, 16'h0000, 0, 4'h0, 0, 0);
        add(0, 4'h0, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 0);

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            req      = vecs[i].req;
            exc_req  = vecs[i].exc;
            exc_code = vecs[i].code;
            tick();
            check_all($sformatf("v%0d", i), vecs[i].show, vecs[i].valid, vecs[i].grant,
                      vecs[i].id, vecs[i].done);
        end

        // Snapshot vs live, then single-requester re-grant refreshing show at ARB.
`ifdef DISP_SCHED_LIVE_EN
        live_exp = 16'hC0DE;
`else
        live_exp = 16'hA000;
`endif
        req = 4'b0001;
        tick();
        check_all("sv_arb", 16'h0000, 0, 4'h0, 0, 0);
        tick();
        check_all("sv_g0", 16'hA000, 1, 4'h1, 0, 0);
        src_data[15:0] = 16'hC0DE;
        tick();
        check_all("sv_g1", live_exp, 1, 4'h1, 0, 0);
        tick();
        check_all("sv_g2", live_exp, 1, 4'h1, 0, 0);
        tick();
        check_all("sv_g3", live_exp, 1, 4'h1, 0, 1);
        tick();
        check_all("sv_gap", live_exp, 1, 4'h0, 0, 0);
        tick();
        check_all("sv_regrant", 16'hC0DE, 1, 4'h1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Time-multiplexes the board's single 4-digit hex display (16-bit `show` word into the digit-scan driver) among several CPU-side sources, e.g. PC, ALU result, register probe.
- Grants the display round-robin, each source for a fixed dwell time.
- An exception request preempts all sources and pins the exception code on the display until it clears.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DWELL_CYCLES, 100_000_000, sysclk cycles each grant is held (1 s at 100 MHz); minimum 2.
- CNT_W, 27, dwell counter width; must satisfy 2**CNT_W > DWELL_CYCLES.

Ports:
- sysclk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_SRC  per-source display request, level.
- src_data  in  16*NUM_SRC  per-source value; source i occupies bits [16i+15:16i].
- exc_req  in  1  exception display request, level.
- exc_code  in  8  exception code to display.
- show  out  16  word to digit-scan driver.
- valid  out  1  show carries a granted value; driver blanks digits when 0.
- grant  out  NUM_SRC  one-hot current owner; all zero in IDLE/ARB/EXC.
- src_id  out  3  index of current owner; 0 when none.
- done  out  1  one-cycle pulse when a dwell completes normally.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, show=16'h0000, valid=0, grant=0, src_id=0, done=0, dwell counter=0, rr_ptr=NUM_SRC-1 (so source 0 wins first).
- States:
  - IDLE: valid=0, show holds its last value. If exc_req → EXC. Otherwise, if any req → ARB.
  - ARB (one cycle): exc_req has priority → EXC. Otherwise pick the first requesting source scanning rr_ptr+1, rr_ptr+2, … modulo NUM_SRC. The winner's src_data is latched into show. Set grant/src_id, valid=1, rr_ptr=winner, counter=0 → SHOW. If req has dropped to 0 by this cycle → IDLE.
  - SHOW: counter increments each cycle. When counter==DWELL_CYCLES-1:
    - done=1 for that cycle and grant clears.
    - Next state is ARB if any req, else IDLE.
    - valid stays 1 until ARB completes or IDLE is entered.
  - EXC: show={8'hEE, exc_code}, updated every cycle while in EXC. valid=1, grant=0, src_id=0. When exc_req goes low → ARB if any req, else IDLE.
- Latency:
  - req rising in IDLE → grant visible 2 cycles later (IDLE→ARB→SHOW edge).
  - exc_req rising → EXC contents visible on the next edge.
- A source's dwell is exactly DWELL_CYCLES cycles of grant high.
- Source drops req mid-SHOW: the dwell still completes with the latched value; no early release.
- Exception preemption during SHOW:
  - grant is withdrawn immediately; done is not pulsed and the counter is discarded.
  - rr_ptr already points at the interrupted source, so it does not get an automatic retry; the scan resumes from the next source.
- exc_req and done in the same cycle: done pulses and the next state is EXC.
- Single requester: it is re-granted back-to-back with one ARB cycle between dwells. show is refreshed from src_data at each ARB.
- reset asserted in any state: next edge returns every register to its reset value, including mid-dwell and mid-EXC.
- Out-of-range src_id width: src_id is zero-extended for NUM_SRC<8.

Optional Feature:
- DISP_SCHED_LIVE_EN
  - Defined: in SHOW, show follows the granted source's src_data every cycle, with a one-cycle register delay.
  - Undefined: show is a snapshot latched at ARB and held constant for the whole dwell.
- All other timing is identical in both builds.

Decomposition:
- Shared package disp_pkg holds:
  - state enum (IDLE, ARB, SHOW, EXC);
  - constant EXC_PREFIX=8'hEE;
  - constant SHOW_W=16.
- One natural sub-module: rr_arbiter. It is combinational next-winner logic taking req and rr_ptr, and producing a one-hot winner plus a found flag. The dwell counter and FSM stay in disp_sched.

Test Plan (DWELL_CYCLES=4, NUM_SRC=4):
- Reset behaviour: reset held 3 cycles with req=4'b1111 → show=0, valid=0, grant=0. After release, ARB picks src 0: grant=4'b0001 for exactly 4 cycles, done pulses on the 4th.
- Round-robin order: req=4'b1010, src1=16'h1234, src3=16'hBEEF → show alternates 1234, BEEF, 1234, …. grant pattern is 0010 then 1000, with one ARB gap between dwells.
- Mid-dwell request drop: req drops to 0 during src 2's dwell → show stays at src 2's value for the full dwell, done pulses, then state goes IDLE and valid=0.
- Exception preemption: exc_req=1 with exc_code=8'h0C in the 2nd cycle of src 0's dwell → next edge show=16'hEE0C, grant=0, no done. After exc_req falls with req=4'b0011, src 1 is granted next.
- Simultaneous exception and done: exc_req rises in the same cycle done pulses → done=1 that cycle, EXC on the next edge.
- Snapshot vs live: src_data changes mid-dwell → show is unchanged without DISP_SCHED_LIVE_EN, and follows one cycle later with it.
